// File: rtl/regfile_sb.sv
// Integer register file with a per-register write-back scoreboard.
// Two combinational read ports and one write port, with optional same-cycle
// write-to-read forwarding. Busy bits mark registers with an in-flight
// producer so decode can stall on RAW hazards. x0 is hardwired to zero and
// never busy.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  output logic                     rs1_ready,
  output logic                     rs2_ready,
  input  logic                     issue_en,
  input  logic [$clog2(NREGS)-1:0] issue_rd,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     flush,
  output logic [NREGS-1:0]         busy_vec
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wr_live;
  logic             rs1_fwd;
  logic             rs2_fwd;

  // x0 writes are dropped so the array never holds a non-zero x0.
  assign wr_live = wr_en && (wr_addr != '0);

  // Forwarding only applies to non-zero addresses being written this cycle.
  assign rs1_fwd = BYPASS && wr_live && (wr_addr == rs1_addr);
  assign rs2_fwd = BYPASS && wr_live && (wr_addr == rs2_addr);

  // Register array: clear on reset, otherwise commit the write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Busy next state: write-back clears first so a same-cycle issue wins;
  // flush discards every pending producer, including one issuing now.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en) begin
        busy_d[wr_addr] = 1'b0;
      end
      if (issue_en && (issue_rd != '0)) begin
        busy_d[issue_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy register; reset overrides everything else in the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read port 1: forwarded data counts as ready even while busy.
  always_comb begin
    rs1_data  = '0;
    rs1_ready = 1'b1;
    if (rs1_addr != '0) begin
      rs1_data  = rs1_fwd ? wr_data : regs_q[rs1_addr];
      rs1_ready = rs1_fwd || !busy_q[rs1_addr];
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    rs2_data  = '0;
    rs2_ready = 1'b1;
    if (rs2_addr != '0) begin
      rs2_data  = rs2_fwd ? wr_data : regs_q[rs2_addr];
      rs2_ready = rs2_fwd || !busy_q[rs2_addr];
    end
  end

  assign busy_vec = busy_q;

  // Keeps the address-width constant referenced for readers and lint alike.
  logic unused_aw;
  assign unused_aw = ^AW;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a forwarding instance, a non-forwarding
// instance sharing its inputs, and a 16 x 64-bit instance.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ie, we, fl;
  logic [4:0]  r1a, r2a, ird, wa;
  logic [31:0] wd;
  logic [31:0] d1, d2, nb_d1, nb_d2;
  logic        rd1, rd2, nb_rd1, nb_rd2;
  logic [31:0] bv, nb_bv;

  logic        w_ie, w_we, w_rd1, w_rd2;
  logic [3:0]  w_r1a, w_r2a, w_ird, w_wa;
  logic [63:0] w_wd, w_d1, w_d2;
  logic [15:0] w_bv;

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .rs1_addr(r1a), .rs2_addr(r2a), .rs1_data(d1), .rs2_data(d2),
    .rs1_ready(rd1), .rs2_ready(rd2), .issue_en(ie), .issue_rd(ird), .wr_en(we),
    .wr_addr(wa), .wr_data(wd), .flush(fl), .busy_vec(bv)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .rs1_addr(r1a), .rs2_addr(r2a), .rs1_data(nb_d1),
    .rs2_data(nb_d2), .rs1_ready(nb_rd1), .rs2_ready(nb_rd2), .issue_en(ie),
    .issue_rd(ird), .wr_en(we), .wr_addr(wa), .wr_data(wd), .flush(fl), .busy_vec(nb_bv)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .BYPASS(1'b1)) dut_w (
    .clk(clk), .rst(rst), .rs1_addr(w_r1a), .rs2_addr(w_r2a), .rs1_data(w_d1),
    .rs2_data(w_d2), .rs1_ready(w_rd1), .rs2_ready(w_rd2), .issue_en(w_ie),
    .issue_rd(w_ird), .wr_en(w_we), .wr_addr(w_wa), .wr_data(w_wd), .flush(1'b0),
    .busy_vec(w_bv)
  );

  // Scoreboard: expectations queued with the stimulus, popped at sample time.
  logic [63:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic expect_v(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_v(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h required %0h", t, obs, e);
      end
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and sampled +1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ie = 1'b0; we = 1'b1; fl = 1'b0;
    r1a = 5'd5; r2a = 5'd0; ird = 5'd0; wa = 5'd5; wd = 32'hDEADBEEF;
    w_ie = 1'b0; w_we = 1'b0; w_r1a = 4'd0; w_r2a = 4'd0; w_ird = 4'd0; w_wa = 4'd0;
    w_wd = 64'd0;
    tick();

    // Reset wins over the concurrent write.
    rst = 1'b0; we = 1'b0;
    expect_v("rst_rd_x5", 64'd0);
    expect_v("rst_busy", 64'd0);
    expect_v("rst_ready", 64'd1);
    expect_v("rst_w_busy", 64'd0);
    #1;
    check_v({32'd0, d1}); check_v({32'd0, bv}); check_v({63'd0, rd1}); check_v({48'd0, w_bv});

    // x0 ignores writes, no forwarding either.
    we = 1'b1; wa = 5'd0; wd = 32'h1234; r1a = 5'd0;
    expect_v("x0_fwd", 64'd0);
    #1;
    check_v({32'd0, d1});
    tick();
    we = 1'b0;
    expect_v("x0_read", 64'd0);
    expect_v("x0_ready", 64'd1);
    #1;
    check_v({32'd0, d1}); check_v({63'd0, rd1});

    // Write x3 with both ports reading it.
    we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5; r1a = 5'd3; r2a = 5'd3;
    expect_v("bypass_rs1", 64'hA5A5A5A5);
    expect_v("bypass_rs2", 64'hA5A5A5A5);
    expect_v("nobypass_rs1_old", 64'd0);
    expect_v("nobypass_rs2_old", 64'd0);
    #1;
    check_v({32'd0, d1}); check_v({32'd0, d2}); check_v({32'd0, nb_d1}); check_v({32'd0, nb_d2});
    tick();
    we = 1'b0;
    expect_v("array_rs1", 64'hA5A5A5A5);
    expect_v("array_rs2", 64'hA5A5A5A5);
    expect_v("nobypass_next", 64'hA5A5A5A5);
    #1;
    check_v({32'd0, d1}); check_v({32'd0, d2}); check_v({32'd0, nb_d1});

    // RAW: issue x7, then wait for its write-back.
    ie = 1'b1; ird = 5'd7;
    tick();
    ie = 1'b0; r1a = 5'd7;
    expect_v("raw_not_ready", 64'd0);
    expect_v("raw_busy7", 64'd1);
    expect_v("raw_nb_not_ready", 64'd0);
    #1;
    check_v({63'd0, rd1}); check_v({63'd0, bv[7]}); check_v({63'd0, nb_rd1});
    tick();
    expect_v("raw_still_stalled", 64'd0);
    #1;
    check_v({63'd0, rd1});
    we = 1'b1; wa = 5'd7; wd = 32'h55;
    expect_v("wb_ready_bypass", 64'd1);
    expect_v("wb_data_bypass", 64'h55);
    expect_v("wb_nb_not_ready", 64'd0);
    expect_v("wb_nb_old_data", 64'd0);
    #1;
    check_v({63'd0, rd1}); check_v({32'd0, d1}); check_v({63'd0, nb_rd1}); check_v({32'd0, nb_d1});
    tick();
    we = 1'b0;
    expect_v("wb_busy7_clear", 64'd0);
    expect_v("wb_nb_ready_next", 64'd1);
    expect_v("wb_nb_data_next", 64'h55);
    #1;
    check_v({63'd0, bv[7]}); check_v({63'd0, nb_rd1}); check_v({32'd0, nb_d1});

    // Issue and write-back to x9 in the same cycle: issue wins.
    ie = 1'b1; ird = 5'd9;
    tick();
    we = 1'b1; wa = 5'd9; wd = 32'h77; r1a = 5'd9;
    tick();
    ie = 1'b0; we = 1'b0;
    expect_v("iss_wb_busy9", 64'd1);
    expect_v("iss_wb_data9", 64'h77);
    expect_v("iss_wb_not_ready", 64'd0);
    #1;
    check_v({63'd0, bv[9]}); check_v({32'd0, d1}); check_v({63'd0, rd1});

    // Flush beats a concurrent issue; a concurrent write still lands.
    ie = 1'b1; ird = 5'd4;
    tick();
    ird = 5'd6;
    tick();
    ie = 1'b0;
    expect_v("pre_flush_busy", 64'h0000_0250);
    #1;
    check_v({32'd0, bv});
    fl = 1'b1; ie = 1'b1; ird = 5'd4; we = 1'b1; wa = 5'd6; wd = 32'h66;
    r1a = 5'd4; r2a = 5'd6;
    tick();
    fl = 1'b0; ie = 1'b0; we = 1'b0;
    expect_v("flush_busy", 64'd0);
    expect_v("flush_rs1_ready", 64'd1);
    expect_v("flush_rs2_ready", 64'd1);
    expect_v("flush_nb_ready", 64'd1);
    expect_v("flush_write_lands", 64'h66);
    #1;
    check_v({32'd0, bv}); check_v({63'd0, rd1}); check_v({63'd0, rd2});
    check_v({63'd0, nb_rd2}); check_v({32'd0, d2});

    // Repeat issue then a single write-back clears; x0 never goes busy.
    ie = 1'b1; ird = 5'd11;
    tick();
    tick();
    ird = 5'd0; we = 1'b1; wa = 5'd11; wd = 32'h11;
    tick();
    ie = 1'b0; we = 1'b0; r1a = 5'd0;
    expect_v("repeat_issue_clear", 64'd0);
    expect_v("x0_issue_ready", 64'd1);
    #1;
    check_v({32'd0, bv}); check_v({63'd0, rd1});

    // 16 x 64 instance.
    w_we = 1'b1; w_wa = 4'd15; w_wd = 64'hFFFF_FFFF_0000_0001; w_r1a = 4'd15;
    expect_v("w_bypass", 64'hFFFF_FFFF_0000_0001);
    #1;
    check_v(w_d1);
    tick();
    w_we = 1'b0; w_ie = 1'b1; w_ird = 4'd15;
    expect_v("w_array", 64'hFFFF_FFFF_0000_0001);
    #1;
    check_v(w_d1);
    tick();
    w_ie = 1'b0;
    expect_v("w_busy15", 64'h8000);
    expect_v("w_not_ready", 64'd0);
    #1;
    check_v({48'd0, w_bv}); check_v({63'd0, w_rd1});
    w_we = 1'b1; w_wd = 64'd2;
    expect_v("w_wb_ready", 64'd1);
    #1;
    check_v({63'd0, w_rd1});
    tick();
    w_we = 1'b0;
    expect_v("w_busy_clear", 64'd0);
    expect_v("w_data2", 64'd2);
    #1;
    check_v({48'd0, w_bv}); check_v(w_d1);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
